// File: rtl/map_table_nway_pkg.sv
// Shared types and helpers for the rename map table and its checkpoint buffer.
package map_table_nway_pkg;

  localparam int NUM_ARCH = 32;
  localparam int AW       = $clog2(NUM_ARCH);
  localparam int NUM_PR   = 64;
  localparam int TW       = $clog2(NUM_PR);
  localparam int WAY      = 2;
  localparam int NUM_CDB  = 2;
  localparam int NUM_CKPT = 4;
  localparam int CW       = $clog2(NUM_CKPT);

  localparam logic [AW-1:0] ZERO_REG  = AW'(31);
  localparam logic [CW:0]   CKPT_FULL = (CW+1)'(NUM_CKPT);

  typedef logic [TW-1:0] tag_t;
  typedef logic [AW-1:0] areg_t;
  typedef logic [CW-1:0] ckpt_id_t;

  typedef struct packed {
    tag_t idx;
    logic ready;
  } map_entry_t;

  typedef struct packed {
    logic valid;
    tag_t tag;
  } cdb_pkt_t;

  // Identity mapping for architectural register r, value is ready.
  function automatic map_entry_t map_entry_reset(input int r);
    map_entry_t e;
    e.idx   = TW'(r);
    e.ready = 1'b1;
    return e;
  endfunction

  function automatic logic cdb_hit(input cdb_pkt_t [NUM_CDB-1:0] cdb, input tag_t tag);
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < NUM_CDB; k++)
      if (cdb[k].valid && cdb[k].tag == tag) hit = 1'b1;
    return hit;
  endfunction

  // Resolve one architectural register for slot j: newest earlier slot writing it
  // wins, otherwise the live map entry with same-cycle broadcasts folded in.
  function automatic map_entry_t rename_lookup(
    input areg_t                     src,
    input int                        j,
    input logic [WAY-1:0]            dv,
    input logic [WAY-1:0][AW-1:0]    dst,
    input logic [WAY-1:0][TW-1:0]    nt,
    input map_entry_t                cur,
    input cdb_pkt_t [NUM_CDB-1:0]    cdb
  );
    map_entry_t res;
    res       = cur;
    res.ready = cur.ready | cdb_hit(cdb, cur.idx);
    for (int i = 0; i < WAY; i++)
      if (i < j && dv[i] && dst[i] == src && dst[i] != ZERO_REG) begin
        res.idx   = nt[i];
        res.ready = 1'b0;
      end
    if (src == ZERO_REG) res.ready = 1'b1;
    return res;
  endfunction

endpackage

// File: rtl/map_table_nway_if.sv
// Dispatch/rename bus between decoder/free list and the map table.
interface map_table_nway_if;
  import map_table_nway_pkg::*;

  logic                        en;
  logic [WAY-1:0]              disp_valid;
  logic [WAY-1:0][AW-1:0]      dest_reg;
  logic [WAY-1:0][AW-1:0]      src_a;
  logic [WAY-1:0][AW-1:0]      src_b;
  logic [WAY-1:0][TW-1:0]      new_T;
  logic [WAY-1:0]              ckpt_req;
  logic [NUM_CDB-1:0]          cdb_valid;
  logic [NUM_CDB-1:0][TW-1:0]  cdb_T;
  logic                        rollback_en;
  ckpt_id_t                    rollback_id;
  logic                        ckpt_release;

  logic [WAY-1:0][TW-1:0]      T1;
  logic [WAY-1:0][TW-1:0]      T2;
  logic [WAY-1:0]              T1_ready;
  logic [WAY-1:0]              T2_ready;
  logic [WAY-1:0][TW-1:0]      Told;
  ckpt_id_t                    ckpt_id;
  logic                        stall;

  modport master (
    output en, disp_valid, dest_reg, src_a, src_b, new_T, ckpt_req,
           cdb_valid, cdb_T, rollback_en, rollback_id, ckpt_release,
    input  T1, T2, T1_ready, T2_ready, Told, ckpt_id, stall
  );

  modport slave (
    input  en, disp_valid, dest_reg, src_a, src_b, new_T, ckpt_req,
           cdb_valid, cdb_T, rollback_en, rollback_id, ckpt_release,
    output T1, T2, T1_ready, T2_ready, Told, ckpt_id, stall
  );

endinterface

// File: rtl/map_table_ckpt_buf.sv
// Circular buffer of map snapshots for one-cycle mispredict recovery.
module map_table_ckpt_buf
  import map_table_nway_pkg::*;
(
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   en,
  input  logic                   alloc,
  input  map_entry_t             snap_in [NUM_ARCH],
  input  logic                   rollback_en,
  input  ckpt_id_t               rollback_id,
  input  logic                   release_req,
  input  cdb_pkt_t [NUM_CDB-1:0] cdb,
  output map_entry_t             restore_map [NUM_ARCH],
  output ckpt_id_t               tail,
  output logic [CW:0]            count
);

  map_entry_t snap [NUM_CKPT][NUM_ARCH];
  ckpt_id_t   head;
  ckpt_id_t   rb_ofs;
  logic       rel;

  assign rb_ofs = rollback_id - head;
  assign rel    = release_req & ~rollback_en & (count != '0);

  // Restore read port, indexed directly by the rollback id.
  always_comb begin
    for (int r = 0; r < NUM_ARCH; r++) restore_map[r] = snap[rollback_id][r];
  end

  // Snapshots track completions; a fresh snapshot already has this cycle's broadcasts.
  always_ff @(posedge clock) begin
    if (en && !reset) begin
      for (int c = 0; c < NUM_CKPT; c++)
        for (int r = 0; r < NUM_ARCH; r++)
          if (cdb_hit(cdb, snap[c][r].idx)) snap[c][r].ready <= 1'b1;
      if (alloc)
        for (int r = 0; r < NUM_ARCH; r++) snap[tail][r] <= snap_in[r];
    end
  end

  // Head/tail/count; rollback frees the restored slot and everything younger.
  always_ff @(posedge clock) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (en) begin
      if (rollback_en) begin
        tail  <= rollback_id;
        count <= {1'b0, rb_ofs};
      end else begin
        if (alloc) tail <= tail + 1'b1;
        if (rel)   head <= head + 1'b1;
        if (alloc && !rel)      count <= count + 1'b1;
        else if (!alloc && rel) count <= count - 1'b1;
      end
    end
  end

  // Rollback must name a live checkpoint.
  a_rollback_live: assert property (@(posedge clock) disable iff (reset)
    (en && rollback_en) |-> ({1'b0, rb_ofs} < count));

endmodule

// File: rtl/map_table_nway.sv
// WAY-wide register rename map table with intra-group bypass and checkpoints.
module map_table_nway
  import map_table_nway_pkg::*;
(
  input logic             clock,
  input logic             reset,
  map_table_nway_if.slave bus
);

  map_entry_t             map_q       [NUM_ARCH];
  map_entry_t             map_d       [NUM_ARCH];
  map_entry_t             snap_in     [NUM_ARCH];
  map_entry_t             restore_map [NUM_ARCH];
  cdb_pkt_t [NUM_CDB-1:0] cdb;
  ckpt_id_t               tail;
  logic [CW:0]            count;
  logic                   stall;
  logic                   alloc;

  // Full is judged before any same-cycle release so stall never depends on it.
  assign stall       = bus.rollback_en | (|bus.ckpt_req & (count == CKPT_FULL));
  assign alloc       = |bus.ckpt_req & ~stall;
  assign bus.stall   = stall;
  assign bus.ckpt_id = tail;

  // Pack broadcasts for the shared lookup helpers.
  always_comb begin
    for (int k = 0; k < NUM_CDB; k++) cdb[k] = '{valid: bus.cdb_valid[k], tag: bus.cdb_T[k]};
  end

  // Rename outputs are driven even when the group is stalled.
  always_comb begin
    map_entry_t ea, eb, eo;
    ea = '0;
    eb = '0;
    eo = '0;
    for (int j = 0; j < WAY; j++) begin
      ea = rename_lookup(bus.src_a[j], j, bus.disp_valid, bus.dest_reg, bus.new_T,
                         map_q[bus.src_a[j]], cdb);
      eb = rename_lookup(bus.src_b[j], j, bus.disp_valid, bus.dest_reg, bus.new_T,
                         map_q[bus.src_b[j]], cdb);
      eo = rename_lookup(bus.dest_reg[j], j, bus.disp_valid, bus.dest_reg, bus.new_T,
                         map_q[bus.dest_reg[j]], cdb);
      bus.T1[j]       = ea.idx;
      bus.T1_ready[j] = ea.ready;
      bus.T2[j]       = eb.idx;
      bus.T2_ready[j] = eb.ready;
      bus.Told[j]     = eo.idx;
    end
  end

  // Next map: restore, then broadcasts, then slots in order; snapshot taken after the branch slot.
  always_comb begin
    for (int r = 0; r < NUM_ARCH; r++) begin
      map_d[r] = bus.rollback_en ? restore_map[r] : map_q[r];
      if (cdb_hit(cdb, map_d[r].idx)) map_d[r].ready = 1'b1;
    end
    snap_in = map_d;
    for (int s = 0; s < WAY; s++) begin
      if (!stall && bus.disp_valid[s] && bus.dest_reg[s] != ZERO_REG)
        map_d[bus.dest_reg[s]] = '{idx: bus.new_T[s], ready: 1'b0};
      if (bus.ckpt_req[s]) snap_in = map_d;
    end
  end

  // Live map register.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int r = 0; r < NUM_ARCH; r++) map_q[r] <= map_entry_reset(r);
    end else if (bus.en) begin
      map_q <= map_d;
    end
  end

  map_table_ckpt_buf u_ckpt (
    .clock       (clock),
    .reset       (reset),
    .en          (bus.en),
    .alloc       (alloc),
    .snap_in     (snap_in),
    .rollback_en (bus.rollback_en),
    .rollback_id (bus.rollback_id),
    .release_req (bus.ckpt_release),
    .cdb         (cdb),
    .restore_map (restore_map),
    .tail        (tail),
    .count       (count)
  );

endmodule

// File: tb/tb_map_table_nway.sv
// Bench for map_table_nway: queue-based reference model plus directed literal checks.
module tb_map_table_nway;
  import map_table_nway_pkg::*;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  map_table_nway_if bus();

  map_table_nway u_dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: live map as plain arrays, checkpoints as an ordered queue of ids.
  int  m_tag [32];
  bit  m_rdy [32];
  int  s_tag [4][32];
  bit  s_rdy [4][32];
  int  ckq [$];
  int  m_head;
  bit  model_live = 1'b0;

  function automatic void m_reset();
    for (int r = 0; r < 32; r++) begin
      m_tag[r] = r;
      m_rdy[r] = 1'b1;
    end
    ckq.delete();
    m_head = 0;
  endfunction

  function automatic bit m_cdb_hit(input int tag);
    for (int k = 0; k < NUM_CDB; k++)
      if (bus.cdb_valid[k] && int'(bus.cdb_T[k]) == tag) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void m_src(input int j, input int s, output int tag, output bit rdy);
    tag = m_tag[s];
    rdy = m_rdy[s] || m_cdb_hit(tag);
    if (s == 31) begin
      rdy = 1'b1;
      return;
    end
    for (int i = j - 1; i >= 0; i--)
      if (bus.disp_valid[i] && int'(bus.dest_reg[i]) == s) begin
        tag = int'(bus.new_T[i]);
        rdy = 1'b0;
        break;
      end
  endfunction

  function automatic bit m_stall();
    return bus.rollback_en || ((bus.ckpt_req != '0) && ckq.size() == 4);
  endfunction

  function automatic int m_next_id();
    return (m_head + ckq.size()) % 4;
  endfunction

  // Model state advance on each rising edge.
  initial forever begin
    @(posedge clock);
    if (reset) begin
      m_reset();
      model_live = 1'b1;
    end else if (bus.en) begin
      bit stl;
      int pre;
      stl = m_stall();
      pre = ckq.size();
      if (bus.rollback_en) begin
        int rid;
        rid = int'(bus.rollback_id);
        for (int r = 0; r < 32; r++) begin
          m_tag[r] = s_tag[rid][r];
          m_rdy[r] = s_rdy[rid][r];
        end
        while (ckq.size() > 0 && ckq[ckq.size()-1] != rid) void'(ckq.pop_back());
        if (ckq.size() > 0) void'(ckq.pop_back());
      end
      for (int r = 0; r < 32; r++) begin
        if (m_cdb_hit(m_tag[r])) m_rdy[r] = 1'b1;
        for (int c = 0; c < 4; c++)
          if (m_cdb_hit(s_tag[c][r])) s_rdy[c][r] = 1'b1;
      end
      if (!stl) begin
        for (int s = 0; s < WAY; s++) begin
          if (bus.disp_valid[s] && int'(bus.dest_reg[s]) != 31) begin
            m_tag[int'(bus.dest_reg[s])] = int'(bus.new_T[s]);
            m_rdy[int'(bus.dest_reg[s])] = 1'b0;
          end
          if (bus.ckpt_req[s]) begin
            int id;
            id = m_next_id();
            for (int r = 0; r < 32; r++) begin
              s_tag[id][r] = m_tag[r];
              s_rdy[id][r] = m_rdy[r];
            end
            ckq.push_back(id);
          end
        end
      end
      if (!bus.rollback_en && bus.ckpt_release && pre > 0) begin
        void'(ckq.pop_front());
        m_head = (m_head + 1) % 4;
      end
    end
  end

  // Compare every output against the model on the falling edge.
  initial forever begin
    @(negedge clock);
    if (!reset && model_live) begin
      for (int j = 0; j < WAY; j++) begin
        int t;
        bit r;
        m_src(j, int'(bus.src_a[j]), t, r);
        chk("model T1", int'(bus.T1[j]), t);
        chk("model T1_ready", int'(bus.T1_ready[j]), int'(r));
        m_src(j, int'(bus.src_b[j]), t, r);
        chk("model T2", int'(bus.T2[j]), t);
        chk("model T2_ready", int'(bus.T2_ready[j]), int'(r));
        m_src(j, int'(bus.dest_reg[j]), t, r);
        chk("model Told", int'(bus.Told[j]), t);
      end
      chk("model stall", int'(bus.stall), int'(m_stall()));
      chk("model ckpt_id", int'(bus.ckpt_id), m_next_id());
    end
  end

  task automatic clear();
    bus.en           = 1'b1;
    bus.disp_valid   = '0;
    bus.dest_reg     = '0;
    bus.src_a        = '0;
    bus.src_b        = '0;
    bus.new_T        = '0;
    bus.ckpt_req     = '0;
    bus.cdb_valid    = '0;
    bus.cdb_T        = '0;
    bus.rollback_en  = 1'b0;
    bus.rollback_id  = '0;
    bus.ckpt_release = 1'b0;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic disp0(input int dst, input int nt, input bit ck);
    bus.disp_valid[0] = 1'b1;
    bus.dest_reg[0]   = AW'(dst);
    bus.new_T[0]      = TW'(nt);
    bus.ckpt_req[0]   = ck;
  endtask

  initial begin
    reset = 1'b1;
    clear();
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    // identity after reset
    clear();
    bus.src_a[0] = 5'd3; bus.dest_reg[0] = 5'd5; bus.src_b[0] = 5'd31;
    #1;
    chk("rst T1", int'(bus.T1[0]), 3);
    chk("rst T1_ready", int'(bus.T1_ready[0]), 1);
    chk("rst Told", int'(bus.Told[0]), 5);
    chk("rst ckpt_id", int'(bus.ckpt_id), 0);
    step();

    // RAW and WAW inside one group
    clear();
    bus.disp_valid = 2'b11;
    bus.dest_reg[0] = 5'd7; bus.new_T[0] = 6'd40;
    bus.src_a[1] = 5'd7; bus.dest_reg[1] = 5'd7; bus.new_T[1] = 6'd41;
    #1;
    chk("raw T1", int'(bus.T1[1]), 40);
    chk("raw T1_ready", int'(bus.T1_ready[1]), 0);
    chk("waw Told1", int'(bus.Told[1]), 40);
    chk("waw Told0", int'(bus.Told[0]), 7);
    step();
    clear();
    bus.src_a[0] = 5'd7;
    #1;
    chk("waw map7", int'(bus.T1[0]), 41);
    chk("waw map7 ready", int'(bus.T1_ready[0]), 0);
    step();

    // CDB bypass, snapshot ready update, rollback
    clear();
    disp0(4, 40, 1'b1);
    #1;
    chk("ck4 ckpt_id", int'(bus.ckpt_id), 0);
    chk("ck4 stall", int'(bus.stall), 0);
    step();
    clear();
    bus.src_a[0] = 5'd4; bus.cdb_valid = 2'b01; bus.cdb_T[0] = 6'd40;
    #1;
    chk("cdb bypass ready", int'(bus.T1_ready[0]), 1);
    step();
    clear();
    disp0(4, 45, 1'b0);
    step();
    clear();
    bus.rollback_en = 1'b1; bus.rollback_id = 2'd0;
    #1;
    chk("rb stall", int'(bus.stall), 1);
    step();
    clear();
    bus.src_a[0] = 5'd4; bus.src_b[0] = 5'd7;
    #1;
    chk("rb map4", int'(bus.T1[0]), 40);
    chk("rb map4 snap ready", int'(bus.T1_ready[0]), 1);
    chk("rb map7", int'(bus.T2[0]), 41);
    chk("rb ckpt_id", int'(bus.ckpt_id), 0);
    step();

    // checkpoint at slot 0 excludes slot 1's write
    clear();
    bus.disp_valid = 2'b11; bus.ckpt_req = 2'b01;
    bus.dest_reg[0] = 5'd2; bus.new_T[0] = 6'd50;
    bus.dest_reg[1] = 5'd2; bus.new_T[1] = 6'd51;
    #1;
    chk("ck2 ckpt_id", int'(bus.ckpt_id), 0);
    step();
    clear();
    bus.src_a[0] = 5'd2;
    #1;
    chk("ck2 live", int'(bus.T1[0]), 51);
    step();
    clear();
    bus.rollback_en = 1'b1; bus.rollback_id = 2'd0;
    #1;
    chk("ck2 rb stall", int'(bus.stall), 1);
    step();
    clear();
    bus.src_a[0] = 5'd2;
    #1;
    chk("ck2 restored", int'(bus.T1[0]), 50);
    chk("ck2 count0 id", int'(bus.ckpt_id), 0);
    step();

    // fill, stall when full, release, wrap
    for (int k = 0; k < 4; k++) begin
      clear();
      disp0(10, 20 + k, 1'b1);
      #1;
      chk("fill ckpt_id", int'(bus.ckpt_id), k);
      chk("fill stall", int'(bus.stall), 0);
      step();
    end
    clear();
    disp0(10, 30, 1'b1);
    #1;
    chk("full stall", int'(bus.stall), 1);
    step();
    clear();
    bus.src_a[0] = 5'd10;
    #1;
    chk("full map unchanged", int'(bus.T1[0]), 23);
    step();
    clear();
    bus.ckpt_release = 1'b1;
    step();
    clear();
    disp0(10, 30, 1'b1);
    #1;
    chk("wrap stall", int'(bus.stall), 0);
    chk("wrap ckpt_id", int'(bus.ckpt_id), 0);
    step();
    clear();
    disp0(10, 31, 1'b1); bus.ckpt_release = 1'b1;
    #1;
    chk("full+rel stall", int'(bus.stall), 1);
    step();
    clear();
    disp0(10, 32, 1'b1); bus.ckpt_release = 1'b1;
    #1;
    chk("alloc+rel stall", int'(bus.stall), 0);
    chk("alloc+rel ckpt_id", int'(bus.ckpt_id), 1);
    step();
    clear();
    bus.rollback_en = 1'b1; bus.rollback_id = 2'd0;
    step();
    clear();
    bus.src_a[0] = 5'd10;
    #1;
    chk("wrap rb map10", int'(bus.T1[0]), 30);
    chk("wrap rb ckpt_id", int'(bus.ckpt_id), 0);
    step();

    // en low holds state
    clear();
    bus.en = 1'b0;
    disp0(12, 33, 1'b1);
    step();
    clear();
    bus.src_a[0] = 5'd12;
    #1;
    chk("hold map12", int'(bus.T1[0]), 12);
    chk("hold ckpt_id", int'(bus.ckpt_id), 0);
    step();

    // zero register is never renamed
    clear();
    disp0(31, 60, 1'b0);
    bus.src_a[1] = 5'd31;
    #1;
    chk("zero bypass T1", int'(bus.T1[1]), 31);
    chk("zero ready", int'(bus.T1_ready[1]), 1);
    chk("zero Told", int'(bus.Told[0]), 31);
    step();
    clear();
    bus.src_a[0] = 5'd31;
    #1;
    chk("zero map", int'(bus.T1[0]), 31);
    step();

    // mixed vector sweep, checked by the model
    for (int n = 0; n < 300; n++) begin
      clear();
      bus.en = ($urandom_range(0, 15) != 0);
      for (int s = 0; s < WAY; s++) begin
        bus.disp_valid[s] = 1'($urandom_range(0, 1));
        bus.dest_reg[s]   = AW'($urandom_range(0, 31));
        bus.src_a[s]      = AW'($urandom_range(0, 1) ? bus.dest_reg[0] : $urandom_range(0, 31));
        bus.src_b[s]      = AW'($urandom_range(0, 31));
        bus.new_T[s]      = TW'($urandom_range(32, 63));
      end
      if ($urandom_range(0, 3) == 0) bus.ckpt_req[$urandom_range(0, 1)] = 1'b1;
      for (int k = 0; k < NUM_CDB; k++) begin
        bus.cdb_valid[k] = 1'($urandom_range(0, 1));
        bus.cdb_T[k]     = TW'($urandom_range(0, 63));
      end
      bus.ckpt_release = ($urandom_range(0, 5) == 0);
      if (ckq.size() > 0 && $urandom_range(0, 11) == 0) begin
        bus.rollback_en = 1'b1;
        bus.rollback_id = CW'(ckq[$urandom_range(0, ckq.size() - 1)]);
      end
      step();
    end

    // reset mid-operation discards checkpoints
    clear();
    reset = 1'b1;
    step();
    reset = 1'b0;
    bus.src_a[0] = 5'd10;
    #1;
    chk("rst2 map10", int'(bus.T1[0]), 10);
    chk("rst2 ready", int'(bus.T1_ready[0]), 1);
    chk("rst2 ckpt_id", int'(bus.ckpt_id), 0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/map_table_nway.md
Name: map_table_nway

Overview:
N-way superscalar register rename map table for the R10000-style core. It renames up to WAY instructions per cycle and resolves intra-group RAW and WAW dependencies. It tracks per-physical-tag ready bits from up to NUM_CDB completion broadcasts, and holds a bounded checkpoint buffer so that branch mispredict rollback restores the map in one cycle. It sits between the decoder/free list and the RS/ROB.

Parameters:
NUM_ARCH, 32, architectural registers; index width AW=$clog2(NUM_ARCH)
NUM_PR, 64, physical registers; tag width TW=$clog2(NUM_PR)
WAY, 2, dispatch slots per cycle
NUM_CDB, 2, completion broadcasts per cycle
NUM_CKPT, 4, checkpoint slots; id width CW=$clog2(NUM_CKPT)
ZERO_REG, 31, hardwired-zero architectural register

Ports:
clock  in  1  clock
reset  in  1  reset, synchronous, active-high
en  in  1  global advance; when 0 state holds, outputs stay valid
disp_valid  in  WAY  slot i dispatching
dest_reg  in  WAY*AW  destination per slot; ZERO_REG = no rename
src_a, src_b  in  WAY*AW  sources per slot
new_T  in  WAY*TW  free-list tag per slot
ckpt_req  in  WAY  slot i is a branch that needs a checkpoint; at most one bit set
cdb_valid  in  NUM_CDB  broadcast valid
cdb_T  in  NUM_CDB*TW  completing tags
rollback_en  in  1  mispredict recovery
rollback_id  in  CW  checkpoint to restore
ckpt_release  in  1  oldest checkpoint's branch resolved correctly
T1, T2  out  WAY*TW  source tags
T1_ready, T2_ready  out  WAY  source ready
Told  out  WAY*TW  previous mapping of dest, sent to ROB
ckpt_id  out  CW  id assigned to this cycle's checkpoint
stall  out  1  group not accepted

Behaviour:
- Reset: map[r] = {tag r, ready 1} for all r; checkpoint head=tail=count=0; snapshots are don't-care.
- Entry point per cycle. Outputs are combinational from current state plus inputs. State updates on posedge when en=1 and reset=0.
- Rename, slot j:
  - T1/T2 come from the newest earlier slot i<j with disp_valid[i], dest_reg[i]==src and dest != ZERO_REG; such a source gets tag new_T[i], ready 0.
  - Otherwise the source reads map[src]; its ready bit is map ready OR any cdb_valid[k] with cdb_T[k]==tag.
  - src==ZERO_REG: always ready 1, tag = map[ZERO_REG].
- Told[j] follows the same newest-earlier-slot rule applied to dest_reg[j], else map[dest].tag.
- stall = rollback_en OR (|ckpt_req AND count==NUM_CKPT).
  - On stall, no slot is applied and no checkpoint is allocated.
  - Rename outputs are still driven.
- Update order for next state:
  - (1) rollback: map = snap[rollback_id]; tail = rollback_id; count = (rollback_id - head) mod NUM_CKPT. The restored checkpoint and all younger ones are freed.
  - (2) CDB: set ready for every entry whose tag matches a valid broadcast. This applies to the live map and to every snapshot.
  - (3) dispatch, if not stalled: slots in order, map[dest]={new_T,0}. Later slots overwrite earlier ones on the same dest. ZERO_REG is never written.
- Checkpoint: if ckpt_req[s] and not stalled, snap[tail] = map after steps 2–3 applied for slots 0..s only. ckpt_id = tail; tail++ (wraps mod NUM_CKPT); count++.
- ckpt_release: head++ and count-- when count>0. It is ignored when rollback_en=1.
  - Release plus allocation in the same cycle leaves count unchanged.
  - This makes the full→allocate case legal only when stall is not raised. stall is computed before release, conservatively.
- Rolling back to a freed or invalid id is undefined. Assertion: rollback_id lies within [head, tail).
- A CDB tag matching new_T in the same cycle does not set ready on the new mapping.
- Reset mid-operation discards all checkpoints.

Decomposition:
- Package rename_pkg: T_t {idx[TW], ready}, MAP_ENTRY reset constant, CKPT_ID_t, and the cdb packet typedef shared with the RS/ROB.
- Sub-module map_table_ckpt_buf: snapshot storage, head/tail/count, per-snapshot CDB ready update, restore read port.
- Top level keeps the live map, the intra-group bypass network and the stall logic.

Test Plan:
- Reset, then read src_a=3 → T1=3, T1_ready=1; dest_reg=5 → Told=5.
- Slot0 dest=7 new_T=40; slot1 src_a=7, dest=7 new_T=41 → T1[1]=40, ready 0; Told[1]=40. Next cycle map[7]=41, ready 0.
- map[4]=40 not ready; cdb_T=40 valid same cycle as src_a=4 → T1_ready=1. Next cycle map[4].ready=1, and any snapshot holding 40 is also ready.
- Checkpoint at slot0 (dest 2→50), slot1 dest 2→51 → ckpt_id=0 holds map[2]=50. Later rollback_id=0 → map[2]=50, count=0, stall=1 that cycle.
- Fill 4 checkpoints, then ckpt_req → stall=1 and map unchanged. Release oldest → next ckpt_req accepted with ckpt_id=0 (wrap).
- dest=ZERO_REG with new_T=60 → map[31] unchanged; src=31 → ready 1.
